// File: rtl/hilo_unit.sv
//==============================================================================
// Module      : hilo_unit
// Description : HI/LO register pair with a pending-result scoreboard for the
//               multi-cycle mul/div engine. Tracks one outstanding operation
//               and stalls MFHI/MFLO reads and new mul/div issues while a
//               result is pending. A younger MTHI/MTLO kills the pending
//               result for that half.
//               Optional feature macro: HILO_BYPASS_EN (same-cycle write
//               forwarding onto r_hi/r_lo, no stall on read-during-done).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module hilo_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_hi_we,
    input  logic             wb_lo_we,
    input  logic [WIDTH-1:0] wb_hi,
    input  logic [WIDTH-1:0] wb_lo,
    input  logic             md_start,
    input  logic             md_done,
    input  logic [WIDTH-1:0] md_hi,
    input  logic [WIDTH-1:0] md_lo,
    input  logic             flush,
    input  logic             rd_req,
    output logic [WIDTH-1:0] r_hi,
    output logic [WIDTH-1:0] r_lo,
    output logic             busy,
    output logic             stall
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             kill_hi;
    logic             kill_lo;
    logic             kill_hi_nxt;
    logic             kill_lo_nxt;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] hi_nxt;
    logic [WIDTH-1:0] lo_nxt;
    logic             in_busy;
    logic             done_ok;
    logic             start_ok;
    logic             md_hi_wr;
    logic             md_lo_wr;

    // Next state, kill bits and register write selection.
    always_comb begin
        in_busy     = (state == BUSY);
        // A result only lands when an op is outstanding and not being flushed.
        done_ok     = in_busy & md_done & ~flush;
        // A start is accepted from IDLE, or from BUSY when the old op retires now.
        start_ok    = md_start & ~flush & (~in_busy | md_done);
        // The younger writeback always wins over the retiring result.
        md_hi_wr    = done_ok & ~kill_hi & ~wb_hi_we;
        md_lo_wr    = done_ok & ~kill_lo & ~wb_lo_we;

        state_nxt   = state;
        kill_hi_nxt = kill_hi;
        kill_lo_nxt = kill_lo;
        if (flush) begin
            state_nxt   = IDLE;
            kill_hi_nxt = 1'b0;
            kill_lo_nxt = 1'b0;
        end else if (start_ok) begin
            state_nxt   = BUSY;
            kill_hi_nxt = 1'b0;
            kill_lo_nxt = 1'b0;
        end else if (done_ok) begin
            state_nxt   = IDLE;
            kill_hi_nxt = 1'b0;
            kill_lo_nxt = 1'b0;
        end else if (in_busy) begin
            kill_hi_nxt = kill_hi | wb_hi_we;
            kill_lo_nxt = kill_lo | wb_lo_we;
        end

        hi_nxt = hi_q;
        lo_nxt = lo_q;
        if (wb_hi_we) begin
            hi_nxt = wb_hi;
        end else if (md_hi_wr) begin
            hi_nxt = md_hi;
        end
        if (wb_lo_we) begin
            lo_nxt = wb_lo;
        end else if (md_lo_wr) begin
            lo_nxt = md_lo;
        end
    end

    // State, kill bits and HI/LO registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            kill_hi <= 1'b0;
            kill_lo <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state   <= state_nxt;
            kill_hi <= kill_hi_nxt;
            kill_lo <= kill_lo_nxt;
            hi_q    <= hi_nxt;
            lo_q    <= lo_nxt;
        end
    end

`ifdef HILO_BYPASS_EN
    // Read values forward same-cycle writes; reading during md_done is safe.
    always_comb begin
        r_hi  = hi_nxt;
        r_lo  = lo_nxt;
        busy  = in_busy;
        stall = ~rst & ~flush &
                ((rd_req & in_busy & ~md_done) |
                 (md_start & in_busy & ~md_done));
    end
`else
    // Read values are the registers; a read colliding with any write waits.
    always_comb begin
        r_hi  = hi_q;
        r_lo  = lo_q;
        busy  = in_busy;
        stall = ~rst & ~flush &
                ((rd_req & in_busy) |
                 (md_start & in_busy & ~md_done) |
                 (rd_req & (wb_hi_we | wb_lo_we | (md_done & in_busy))));
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_hilo_unit.sv
//==============================================================================
// Module      : tb_hilo_unit
// Description : Self-checking bench for hilo_unit: a directed vector table
//               followed by random traffic compared against a behavioural
//               ownership model of the HI/LO scoreboard.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_hilo_unit;

    localparam int W = 32;
`ifdef HILO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         wb_hi_we, wb_lo_we;
    logic [W-1:0] wb_hi, wb_lo;
    logic         md_start, md_done;
    logic [W-1:0] md_hi, md_lo;
    logic         flush, rd_req;
    logic [W-1:0] r_hi, r_lo;
    logic         busy, stall;

    hilo_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .wb_hi_we(wb_hi_we), .wb_lo_we(wb_lo_we),
        .wb_hi(wb_hi), .wb_lo(wb_lo),
        .md_start(md_start), .md_done(md_done),
        .md_hi(md_hi), .md_lo(md_lo),
        .flush(flush), .rd_req(rd_req),
        .r_hi(r_hi), .r_lo(r_lo),
        .busy(busy), .stall(stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rst, hwe, lwe;
        logic [W-1:0] wbh, wbl;
        logic         st, dn;
        logic [W-1:0] mdh, mdl;
        logic         fl, rd;
        logic         es, eb;
        logic [W-1:0] eh, el;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    // Reference model: an op is pending or not; while pending, the result
    // still "owns" each half until a younger writeback takes it away.
    bit           m_pending = 0;
    bit           m_own_hi  = 0;
    bit           m_own_lo  = 0;
    logic [W-1:0] m_hi      = '0;
    logic [W-1:0] m_lo      = '0;

    vec_t tbl [35];

    function automatic vec_t mk(input logic r, hw, lw, input logic [W-1:0] bh, bl,
                                input logic s, d, input logic [W-1:0] mh, ml,
                                input logic f, rq, input logic es, eb,
                                input logic [W-1:0] eh, el);
        vec_t v;
        v.rst = r;  v.hwe = hw; v.lwe = lw; v.wbh = bh; v.wbl = bl;
        v.st = s;   v.dn = d;   v.mdh = mh; v.mdl = ml; v.fl = f; v.rd = rq;
        v.es = es;  v.eb = eb;  v.eh = eh;  v.el = el;
        return v;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // One clock: drive at negedge, check mid-cycle, advance model at posedge.
    task automatic cycle(input vec_t v, input bit use_tbl, input string tag);
        bit           wr_hi, wr_lo, e_stall;
        logic [W-1:0] e_hi, e_lo;
        @(negedge clk);
        rst = v.rst; wb_hi_we = v.hwe; wb_lo_we = v.lwe; wb_hi = v.wbh; wb_lo = v.wbl;
        md_start = v.st; md_done = v.dn; md_hi = v.mdh; md_lo = v.mdl;
        flush = v.fl; rd_req = v.rd;
        #1;
        wr_hi = m_pending && v.dn && !v.fl && m_own_hi && !v.hwe;
        wr_lo = m_pending && v.dn && !v.fl && m_own_lo && !v.lwe;
        e_hi  = (BYP && v.hwe) ? v.wbh : (BYP && wr_hi) ? v.mdh : m_hi;
        e_lo  = (BYP && v.lwe) ? v.wbl : (BYP && wr_lo) ? v.mdl : m_lo;
        if (v.rst || v.fl) e_stall = 0;
        else e_stall = (v.rd && m_pending && !(v.dn && BYP))
                    || (v.st && m_pending && !v.dn)
                    || (!BYP && v.rd && (v.hwe || v.lwe || (m_pending && v.dn)));
        chk($sformatf("%s stall", tag), {31'd0, stall}, {31'd0, e_stall});
        chk($sformatf("%s busy",  tag), {31'd0, busy},  {31'd0, m_pending});
        chk($sformatf("%s r_hi",  tag), r_hi, e_hi);
        chk($sformatf("%s r_lo",  tag), r_lo, e_lo);
        if (use_tbl && !BYP) begin
            chk($sformatf("%s tbl_stall", tag), {31'd0, stall}, {31'd0, v.es});
            chk($sformatf("%s tbl_busy",  tag), {31'd0, busy},  {31'd0, v.eb});
            chk($sformatf("%s tbl_r_hi",  tag), r_hi, v.eh);
            chk($sformatf("%s tbl_r_lo",  tag), r_lo, v.el);
        end
        @(posedge clk);
        if (v.rst) begin
            m_pending = 0; m_own_hi = 0; m_own_lo = 0; m_hi = '0; m_lo = '0;
        end else begin
            if (v.hwe) m_hi = v.wbh; else if (wr_hi) m_hi = v.mdh;
            if (v.lwe) m_lo = v.wbl; else if (wr_lo) m_lo = v.mdl;
            if (v.fl) begin
                m_pending = 0;
            end else if (m_pending && v.dn) begin
                m_pending = v.st; m_own_hi = 1; m_own_lo = 1;
            end else if (!m_pending && v.st) begin
                m_pending = 1; m_own_hi = 1; m_own_lo = 1;
            end else if (m_pending) begin
                if (v.hwe) m_own_hi = 0;
                if (v.lwe) m_own_lo = 0;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;
        //              rst hw lw wbh       wbl      st dn mdh       mdl       fl rd  es eb eh        el
        tbl[0]  = mk(1, 0, 0, 0,        0,       0, 0, 0,        0,        0, 0,  0, 0, 0,        0);
        tbl[1]  = mk(0, 1, 0, 'h1234,   0,       0, 0, 0,        0,        0, 0,  0, 0, 0,        0);
        tbl[2]  = mk(0, 0, 0, 0,        0,       0, 0, 0,        0,        0, 0,  0, 0, 'h1234,   0);
        tbl[3]  = mk(0, 0, 0, 0,        0,       1, 0, 0,        0,        0, 0,  0, 0, 'h1234,   0);
        tbl[4]  = mk(0, 0, 0, 0,        0,       0, 0, 0,        0,        0, 1,  1, 1, 'h1234,   0);
        tbl[5]  = mk(0, 0, 0, 0,        0,       0, 0, 0,        0,        0, 1,  1, 1, 'h1234,   0);
        tbl[6]  = mk(0, 0, 0, 0,        0,       0, 0, 0,        0,        0, 1,  1, 1, 'h1234,   0);
        tbl[7]  = mk(0, 0, 0, 0,        0,       0, 1, 'hAAAA,   'h5555,   0, 1,  1, 1, 'h1234,   0);
        tbl[8]  = mk(0, 0, 0, 0,        0,       0, 0, 0,        0,        0, 0,  0, 0, 'hAAAA,   'h5555);
        tbl[9]  = mk(0, 0, 0, 0,        0,       1, 0, 0,        0,        0, 0,  0, 0, 'hAAAA,   'h5555);
        tbl[10] = mk(0, 0, 1, 0,        'h77,    0, 0, 0,        0,        0, 0,  0, 1, 'hAAAA,   'h5555);
        tbl[11] = mk(0, 0, 0, 0,        0,       0, 1, 1,        2,        0, 0,  0, 1, 'hAAAA,   'h77);
        tbl[12] = mk(0, 0, 0, 0,        0,       0, 0, 0,        0,        0, 0,  0, 0, 1,        'h77);
        tbl[13] = mk(0, 0, 0, 0,        0,       1, 0, 0,        0,        0, 0,  0, 0, 1,        'h77);
        tbl[14] = mk(0, 0, 0, 0,        0,       0, 0, 0,        0,        1, 0,  0, 1, 1,        'h77);
        tbl[15] = mk(0, 0, 0, 0,        0,       0, 1, 9,        9,        0, 0,  0, 0, 1,        'h77);
        tbl[16] = mk(0, 0, 0, 0,        0,       0, 0, 0,        0,        0, 0,  0, 0, 1,        'h77);
        tbl[17] = mk(0, 0, 0, 0,        0,       1, 0, 0,        0,        0, 0,  0, 0, 1,        'h77);
        tbl[18] = mk(0, 0, 1, 0,        'h66,    1, 0, 0,        0,        0, 0,  1, 1, 1,        'h77);
        tbl[19] = mk(0, 0, 0, 0,        0,       1, 1, 3,        4,        0, 0,  0, 1, 1,        'h66);
        tbl[20] = mk(0, 0, 0, 0,        0,       0, 0, 0,        0,        0, 0,  0, 1, 3,        'h66);
        tbl[21] = mk(0, 0, 0, 0,        0,       0, 1, 7,        8,        0, 0,  0, 1, 3,        'h66);
        tbl[22] = mk(0, 0, 0, 0,        0,       0, 0, 0,        0,        0, 0,  0, 0, 7,        8);
        tbl[23] = mk(0, 0, 0, 0,        0,       1, 0, 0,        0,        0, 0,  0, 0, 7,        8);
        tbl[24] = mk(0, 1, 0, 'hC,      0,       0, 1, 'hD,      'hE,      0, 0,  0, 1, 7,        8);
        tbl[25] = mk(0, 0, 0, 0,        0,       0, 0, 0,        0,        0, 0,  0, 0, 'hC,      'hE);
        tbl[26] = mk(0, 0, 0, 0,        0,       1, 0, 0,        0,        0, 0,  0, 0, 'hC,      'hE);
        tbl[27] = mk(1, 0, 0, 0,        0,       0, 0, 0,        0,        0, 0,  0, 1, 'hC,      'hE);
        tbl[28] = mk(0, 0, 0, 0,        0,       0, 1, 'hF,      'hF,      0, 0,  0, 0, 0,        0);
        tbl[29] = mk(0, 0, 0, 0,        0,       0, 0, 0,        0,        0, 0,  0, 0, 0,        0);
        tbl[30] = mk(0, 0, 1, 0,        'h10,    0, 0, 0,        0,        0, 1,  1, 0, 0,        0);
        tbl[31] = mk(0, 0, 0, 0,        0,       0, 0, 0,        0,        0, 1,  0, 0, 0,        'h10);
        tbl[32] = mk(0, 0, 0, 0,        0,       1, 0, 0,        0,        0, 0,  0, 0, 0,        'h10);
        tbl[33] = mk(0, 0, 0, 0,        0,       0, 0, 0,        0,        1, 1,  0, 1, 0,        'h10);
        tbl[34] = mk(0, 0, 0, 0,        0,       0, 0, 0,        0,        0, 0,  0, 0, 0,        'h10);

        rst = 1; wb_hi_we = 0; wb_lo_we = 0; wb_hi = '0; wb_lo = '0;
        md_start = 0; md_done = 0; md_hi = '0; md_lo = '0; flush = 0; rd_req = 0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 35; i++) begin
            cycle(tbl[i], 1'b1, $sformatf("vec%0d", i));
        end

        for (int n = 0; n < 3000; n++) begin
            rv.rst = ($urandom_range(63) == 0);
            rv.hwe = ($urandom_range(5) == 0);
            rv.lwe = ($urandom_range(5) == 0);
            rv.wbh = $urandom;
            rv.wbl = $urandom;
            rv.st  = ($urandom_range(3) == 0);
            rv.dn  = ($urandom_range(3) == 0);
            rv.mdh = $urandom;
            rv.mdl = $urandom;
            rv.fl  = ($urandom_range(15) == 0);
            rv.rd  = ($urandom_range(2) == 0);
            rv.es = 0; rv.eb = 0; rv.eh = '0; rv.el = '0;
            cycle(rv, 1'b0, $sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
